// File: rtl/config_loader.sv
// rtl/config_loader.sv - word-serial configuration loader with XOR checksum and atomic commit
//
// Assembles NWORDS bitstream words into a shadow register, verifies a trailing
// XOR checksum word, then commits the shadow to config_out in one edge.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   start         one-cycle pulse: begin (or restart) a load
//   in_data       bitstream word
//   in_valid      in_data is valid
//   in_ready      loader accepts a word this cycle
//   config_out    committed configuration word
//   config_valid  config_out holds a checksum-verified configuration
//   busy          a load is in progress
//   done          one-cycle pulse after a successful commit
//   error         sticky: last load failed its checksum
module config_loader #(
    parameter int CONFIG_WIDTH = 65,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int NWORDS    = (CONFIG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int PAD_WIDTH = NWORDS * DATA_WIDTH;
    localparam int CNT_W     = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       count;
    // Shadow is padded to a whole number of words; the pad bits of the last
    // word are stored but never reach config_out.
    logic [PAD_WIDTH-1:0]   shadow;
    logic [DATA_WIDTH-1:0]  acc;
    logic                   handshake;

    assign handshake = in_valid & in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            count        <= '0;
            shadow       <= '0;
            acc          <= '0;
            config_out   <= '0;
            config_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            in_ready     <= 1'b0;
        end else begin
            done <= 1'b0;
            // start takes priority in every state; a handshake in the same
            // cycle is deliberately dropped so a restart always begins clean.
            if (start) begin
                state    <= S_LOAD;
                count    <= '0;
                shadow   <= '0;
                acc      <= '0;
                error    <= 1'b0;
                in_ready <= 1'b1;
                busy     <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                    S_LOAD: begin
                        if (handshake) begin
                            for (int k = 0; k < NWORDS; k++) begin
                                if (count == CNT_W'(k)) begin
                                    shadow[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                                end
                            end
                            acc <= acc ^ in_data;
                            // Counter stops at the last index instead of wrapping.
                            if (count == LAST_WORD) begin
                                state <= S_CHECK;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (handshake) begin
                            // Full-width compare: pad bits of the last word count.
                            if (in_data == acc) begin
                                config_out   <= shadow[CONFIG_WIDTH-1:0];
                                config_valid <= 1'b1;
                                done         <= 1'b1;
                            end else begin
                                error <= 1'b1;
                            end
                            state    <= S_IDLE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - self-checking bench for config_loader
module tb_config_loader;

    typedef logic [8:0][7:0] words_t;

    typedef struct {
        words_t      w;
        logic [7:0]  chk;
        logic [64:0] exp_cfg;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [64:0] config_out;
    logic        config_valid;
    logic        busy;
    logic        done;
    logic        error;

    int compared;
    int mismatched;

    logic [64:0] m_cfg;
    logic        m_valid;
    logic        m_err;

    config_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .config_out   (config_out),
        .config_valid (config_valid),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected config: word k lands at bit 8*k, anything above bit 64 is lost.
    function automatic logic [64:0] ref_cfg(input words_t w);
        logic [64:0] c;
        c = '0;
        for (int k = 0; k < 9; k++) c = c | (65'(w[k]) << (8 * k));
        return c;
    endfunction

    function automatic logic [7:0] ref_chk(input words_t w);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < 9; k++) x = x ^ w[k];
        return x;
    endfunction

    task automatic pulse_start(input logic junk);
        start = 1'b1;
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
        end
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input int gap);
        int n;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            check("stall_hold_cfg", config_out, m_cfg);
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("ready_timeout", 65'(in_ready), 65'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_load(input words_t w, input logic [7:0] chk, input int max_gap, input logic junk);
        logic good;
        good = (chk == ref_chk(w));
        pulse_start(junk);
        check("busy_after_start", 65'(busy), 65'd1);
        check("error_cleared_by_start", 65'(error), 65'd0);
        for (int k = 0; k < 9; k++) begin
            send_word(w[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            check("no_partial_cfg", config_out, m_cfg);
            check("valid_held", 65'(config_valid), 65'(m_valid));
        end
        send_word(chk, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        if (good) begin
            m_cfg   = ref_cfg(w);
            m_valid = 1'b1;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        check("cfg_after_chk", config_out, m_cfg);
        check("valid_after_chk", 65'(config_valid), 65'(m_valid));
        check("error_after_chk", 65'(error), 65'(m_err));
        check("done_pulse", 65'(done), 65'(good));
        check("busy_after_chk", 65'(busy), 65'd0);
        check("ready_after_chk", 65'(in_ready), 65'd0);
        tick();
        check("done_one_cycle", 65'(done), 65'd0);
        check("error_sticky", 65'(error), 65'(m_err));
    endtask

    vec_t tbl[4];

    initial begin
        words_t t1, t6, wa, wb, wr;
        logic [7:0] c;

        compared   = 0;
        mismatched = 0;
        m_cfg      = '0;
        m_valid    = 1'b0;
        m_err      = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;

        t1 = {8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        t6 = {8'hFF, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

        tbl[0] = '{w: t1, chk: 8'h0A, exp_cfg: 65'd0, exp_valid: 1'b0, exp_err: 1'b1};
        tbl[1] = '{w: t1, chk: 8'h09, exp_cfg: {1'b1, 64'h0807060504030201}, exp_valid: 1'b1, exp_err: 1'b0};
        tbl[2] = '{w: t6, chk: 8'h77, exp_cfg: {1'b1, 64'h8877665544332211}, exp_valid: 1'b1, exp_err: 1'b0};
        tbl[3] = '{w: t6, chk: 8'h00, exp_cfg: {1'b1, 64'h8877665544332211}, exp_valid: 1'b1, exp_err: 1'b1};

        tick();
        tick();
        check("rst_cfg", config_out, 65'd0);
        check("rst_valid", 65'(config_valid), 65'd0);
        check("rst_busy", 65'(busy), 65'd0);
        check("rst_done", 65'(done), 65'd0);
        check("rst_error", 65'(error), 65'd0);
        check("rst_ready", 65'(in_ready), 65'd0);
        reset = 1'b0;
        tick();

        // Table-driven loads: mismatch, good, pad-bit load, mismatch after commit
        for (int i = 0; i < 4; i++) begin
            run_load(tbl[i].w, tbl[i].chk, 0, 1'b0);
            check("tbl_cfg", config_out, tbl[i].exp_cfg);
            check("tbl_valid", 65'(config_valid), 65'(tbl[i].exp_valid));
            check("tbl_error", 65'(error), 65'(tbl[i].exp_err));
        end

        // Test 3: stalls between words give the same result as test 1
        run_load(t1, 8'h09, 5, 1'b0);
        check("stall_cfg", config_out, {1'b1, 64'h0807060504030201});

        // Test 4: abandoned partial load, restart with junk handshake, new pattern
        wa = {8'hA9, 8'hA8, 8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1};
        wb = {8'h5A, 8'h3C, 8'hC3, 8'h96, 8'h69, 8'h0F, 8'hF0, 8'h81, 8'h18};
        pulse_start(1'b0);
        for (int k = 0; k < 4; k++) send_word(wa[k], 0);
        check("partial_hold_cfg", config_out, {1'b1, 64'h0807060504030201});
        run_load(wb, ref_chk(wb), 2, 1'b1);
        check("restart_cfg", config_out, ref_cfg(wb));

        // Test 5: asynchronous reset mid-cycle after 5 words
        pulse_start(1'b0);
        for (int k = 0; k < 5; k++) send_word(t6[k], 0);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_cfg", config_out, 65'd0);
        check("async_rst_valid", 65'(config_valid), 65'd0);
        check("async_rst_busy", 65'(busy), 65'd0);
        check("async_rst_ready", 65'(in_ready), 65'd0);
        tick();
        tick();
        reset   = 1'b0;
        m_cfg   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        tick();
        run_load(t1, 8'h09, 1, 1'b0);
        check("post_rst_cfg", config_out, {1'b1, 64'h0807060504030201});

        // Test 6: words offered while idle are not accepted
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_no_ready", 65'(in_ready), 65'd0);
        end
        in_valid = 1'b0;
        run_load(t6, 8'h77, 0, 1'b0);
        check("pad_bit64", 65'(config_out[64]), 65'd1);

        // Randomised loads against the reference model
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 9; k++) wr[k] = 8'($urandom);
            c = ref_chk(wr);
            if ($urandom_range(0, 3) == 0) c = c ^ (8'd1 << $urandom_range(0, 7));
            run_load(wr, c, 3, ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    always @(negedge clock) begin
        if (!reset && done && error) begin
            compared++;
            mismatched++;
            $display("FAIL done_error_exclusive: done=%0b error=%0b required not both", done, error);
        end
    end

endmodule
